// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the palette DMA: controller state type and encodings.
package jtkiwi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/jtkiwi_paldma_edge.sv
// Edge detector for LVBL: flags 1->0 (blank start) and 0->1 (blank end)
// between consecutive cycles. History resets high so a low input at release counts as a fall.
module jtkiwi_paldma_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b1;
    else     sig_q <= sig_d;
  end

  assign fall = sig_q & ~sig;
  assign rise = ~sig_q & sig;

endmodule

// File: rtl/jtkiwi_paldma.sv
// Palette DMA: copies LEN source bytes into palette RAM during vertical blank.
// Build option JTKIWI_PALDMA_SWAP_EN swaps the two bytes of each colour entry on the palette side.
//
// state    | meaning
// ST_IDLE  | waiting for dma_en
// ST_ARMED | enabled, waiting for LVBL falling edge
// ST_REQ   | src_cs high, waiting for src_ok
// ST_WRITE | one-cycle palette write, counter advances
module jtkiwi_paldma
  import jtkiwi_pkg::*;
#(
  parameter int AW  = 10,
  parameter int LEN = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic          dma_en,
  output logic [AW-1:0] src_addr,
  output logic          src_cs,
  input  logic          src_ok,
  input  logic [7:0]    src_data,
  output logic [AW-1:0] pal_addr,
  output logic [7:0]    pal_dout,
  output logic          pal_we,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'(LEN - 1);

  dma_state_t  state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        lvbl_fall, lvbl_rise;
  logic        last_byte;

  jtkiwi_paldma_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (LVBL),
    .fall (lvbl_fall),
    .rise (lvbl_rise)
  );

  assign last_byte = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // A blank start outranks dma_en dropping in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (dma_en) state_d = ST_ARMED;
      ST_ARMED: begin
        if (lvbl_fall)    state_d = ST_REQ;
        else if (!dma_en) state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (lvbl_rise)   state_d = ST_IDLE;
        else if (src_ok) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (lvbl_rise || last_byte) state_d = ST_IDLE;
        else                        state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; blank end wins over completion so done never follows an abort.
  always_comb begin
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_ARMED: if (lvbl_fall) cnt_d = '0;
      ST_REQ: begin
        if (lvbl_rise)   abort_d = 1'b1;
        else if (src_ok) data_d  = src_data;
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (lvbl_rise)      abort_d = 1'b1;
        else if (last_byte) done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    src_cs = (state_q == ST_REQ);
    pal_we = (state_q == ST_WRITE);
    busy   = (state_q == ST_REQ) || (state_q == ST_WRITE);
  end

  assign src_addr = cnt_q[AW-1:0];
  assign pal_dout = data_q;
  assign done     = done_q;
  assign abort    = abort_q;

`ifdef JTKIWI_PALDMA_SWAP_EN
  // Swap applied only while writing so the idle address still reads as the counter.
  assign pal_addr = cnt_q[AW-1:0] ^ {{(AW-1){1'b0}}, pal_we};
`else
  assign pal_addr = cnt_q[AW-1:0];
`endif

endmodule

// File: tb/tb_jtkiwi_paldma.sv
// Randomized bench for jtkiwi_paldma: the bench acts as byte source with random latency
// and checks every palette write against a byte-index model of the transfer.
module tb_jtkiwi_paldma;

  localparam int AW  = 10;
  localparam int LEN = 1024;

  logic          clk = 1'b0;
  logic          rst, LVBL, dma_en, src_ok, src_cs, pal_we, busy, done, abort;
  logic [AW-1:0] src_addr, pal_addr;
  logic [7:0]    src_data, pal_dout;

  always #5 clk = ~clk;

  jtkiwi_paldma #(.AW(AW), .LEN(LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .LVBL     (LVBL),
    .dma_en   (dma_en),
    .src_addr (src_addr),
    .src_cs   (src_cs),
    .src_ok   (src_ok),
    .src_data (src_data),
    .pal_addr (pal_addr),
    .pal_dout (pal_dout),
    .pal_we   (pal_we),
    .busy     (busy),
    .done     (done),
    .abort    (abort)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [LEN];
  int wr_count, done_cnt, abort_cnt, cs_cnt, we_cnt, at7_cnt, last_addr;
  int fixed_delay, w;
  bit slow7, w_loaded, end_ok;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pal_idx(input int i);
`ifdef JTKIWI_PALDMA_SWAP_EN
    return i ^ 1;
`else
    return i;
`endif
  endfunction

  // One cycle: sample at the falling edge, then act as the source for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (pal_we) begin
        we_cnt++;
        if (wr_count < LEN) begin
          chk("wr_addr", pal_addr, pal_idx(wr_count));
          chk("wr_data", pal_dout, mem[wr_count]);
        end else begin
          chk("wr_overrun", wr_count, LEN - 1);
        end
        last_addr = pal_addr;
        wr_count++;
      end
      if (src_cs) begin
        cs_cnt++;
        chk("req_addr", src_addr, wr_count % (1 << AW));
        chk("cs_we_excl", pal_we, 0);
        if (wr_count == 7) at7_cnt++;
      end
      chk("busy", busy, src_cs | pal_we);
      if (done)  done_cnt++;
      if (abort) abort_cnt++;
    end
    if (src_cs && !rst) begin
      if (!w_loaded) begin
        if (slow7 && wr_count == 7) w = 5;
        else if (fixed_delay >= 0)  w = fixed_delay;
        else                        w = $urandom_range(0, 3);
        w_loaded = 1'b1;
      end
      if (w == 0) begin
        src_ok   = 1'b1;
        src_data = mem[src_addr];
        w_loaded = 1'b0;
      end else begin
        w--;
        src_ok   = 1'b0;
        src_data = 8'($urandom);
      end
    end else begin
      // stray acknowledges with junk data while nothing is requested
      w_loaded = 1'b0;
      src_ok   = ($urandom_range(0, 3) == 0);
      src_data = 8'($urandom);
    end
  endtask

  task automatic clear_counts();
    wr_count = 0; done_cnt = 0; abort_cnt = 0; cs_cnt = 0;
    we_cnt = 0; at7_cnt = 0; last_addr = -1;
  endtask

  task automatic start_xfer();
    clear_counts();
    for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    LVBL   = 1'b1;
    dma_en = 1'b1;
    repeat (2 + $urandom_range(0, 3)) tick();
    LVBL = 1'b0;
  endtask

  task automatic finish_xfer();
    dma_en = 1'b0;
    repeat (3) tick();
    LVBL = 1'b1;
    repeat (3) tick();
  endtask

  // Runs until done/abort; with k_abort >= 0 the blank ends right after write k_abort
  // (during that write or in the following request cycle).
  task automatic wait_end(input int k_abort, input int budget, output bit ok);
    int  cyc;
    bit  raised;
    cyc = 0; raised = 1'b0; ok = 1'b0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (done_cnt > 0 || abort_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      if (!raised && k_abort >= 0 && wr_count == k_abort) begin
        if ($urandom_range(0, 1) == 1) begin
          tick();
          cyc++;
        end
        LVBL   = 1'b1;
        raised = 1'b1;
      end
    end
    if (!ok) chk("timeout", cyc, -1);
  endtask

  task automatic run_abort(input string tag, input int k);
    start_xfer();
    wait_end(k, 6000, end_ok);
    repeat (5) tick();
    chk({tag, "_writes"}, wr_count, k);
    chk({tag, "_we_total"}, we_cnt, k);
    chk({tag, "_abort"}, abort_cnt, 1);
    chk({tag, "_done"}, done_cnt, 0);
    chk({tag, "_last"}, last_addr, pal_idx(k - 1));
    chk({tag, "_busy"}, busy, 0);
    finish_xfer();
  endtask

  initial begin
    rst = 1'b1; LVBL = 1'b1; dma_en = 1'b0; src_ok = 1'b0; src_data = '0;
    fixed_delay = -1; slow7 = 1'b0; w = 0; w_loaded = 1'b0; end_ok = 1'b0;
    clear_counts();

    #12;
    chk("rst_src_cs", src_cs, 0);
    chk("rst_pal_we", pal_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_pal_addr", pal_addr, 0);
    chk("rst_pal_dout", pal_dout, 0);
    @(negedge clk);
    rst = 1'b0;

    // full transfer, source answers one cycle after each request
    fixed_delay = 1;
    start_xfer();
    wait_end(-1, 8000, end_ok);
    chk("full_writes", wr_count, LEN);
    chk("full_done", done_cnt, 1);
    chk("full_abort", abort_cnt, 0);
    chk("full_last", last_addr, pal_idx(LEN - 1));
    chk("full_busy", busy, 0);
    done_cnt = 0; cs_cnt = 0;
    repeat (20) tick();
    chk("no_rearm_cs", cs_cnt, 0);
    chk("no_rearm_done", done_cnt, 0);
    finish_xfer();

    // random latency, byte 7 held off for 5 cycles
    fixed_delay = -1;
    slow7 = 1'b1;
    start_xfer();
    wait_end(-1, 12000, end_ok);
    slow7 = 1'b0;
    chk("slow_writes", wr_count, LEN);
    chk("slow_done", done_cnt, 1);
    chk("slow_at7_cycles", at7_cnt, 6);
    finish_xfer();

    run_abort("abort300", 300);
    run_abort("abort_rand", $urandom_range(1, LEN - 2));

    // reset in the middle of a transfer
    start_xfer();
    begin
      int cyc;
      cyc = 0;
      while (wr_count < 50 && cyc < 2000) begin
        tick();
        cyc++;
      end
    end
    chk("rst_mid_reached", wr_count, 50);
    rst = 1'b1;
    #1;
    chk("rst_mid_src_cs", src_cs, 0);
    chk("rst_mid_pal_we", pal_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_src_addr", src_addr, 0);
    chk("rst_mid_pal_dout", pal_dout, 0);
    dma_en = 1'b0;
    LVBL   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start_xfer();
    wait_end(-1, 12000, end_ok);
    chk("restart_writes", wr_count, LEN);
    chk("restart_done", done_cnt, 1);
    finish_xfer();

    // disarm before blank start
    clear_counts();
    LVBL = 1'b1; dma_en = 1'b1;
    repeat (3) tick();
    dma_en = 1'b0;
    repeat (2) tick();
    LVBL = 1'b0;
    repeat (10) tick();
    chk("disarm_cs", cs_cnt, 0);
    chk("disarm_we", we_cnt, 0);
    chk("disarm_busy", busy, 0);
    LVBL = 1'b1;
    repeat (2) tick();

    // blank start and dma_en drop together: transfer still starts
    clear_counts();
    for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
    dma_en = 1'b1;
    repeat (3) tick();
    dma_en = 1'b0;
    LVBL   = 1'b0;
    tick();
    chk("start_wins_busy", busy, 1);
    wait_end(10, 2000, end_ok);
    chk("start_wins_writes", wr_count, 10);
    chk("start_wins_abort", abort_cnt, 1);
    finish_xfer();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule
